// File: rtl/mul_sched.sv
// Two-requester arbiter in front of one iterative shift-add multiplier.
// A request is accepted in IDLE, multiplied over W RUN cycles and held in DONE until taken.
module mul_sched #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_data,
    output logic           rsp_id,
    output logic           busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] ext_a;
    logic           id;
    logic           last;
    logic           grant0;
    logic           grant1;

    // last==1 means requester 1 was granted last, so requester 0 wins a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && (!req1_valid || last)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == DONE);
    assign rsp_data   = rsp_valid ? acc : '0;
    assign rsp_id     = rsp_valid & id;
    assign ext_a      = {{W{1'b0}}, op_a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            cnt   <= '0;
            acc   <= '0;
            id    <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_a  <= grant1 ? req1_a : req0_a;
                        op_b  <= grant1 ? req1_b : req0_b;
                        id    <= grant1;
                        last  <= grant1;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (op_b[cnt]) begin
                        acc <= acc + (ext_a << cnt);
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed and random transactions against a grant/product reference model.
module tb_mul_sched;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           req0_ready, req1_ready;
    logic           rsp_valid, rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic           rsp_id;
    logic           busy;

    int checks = 0;
    int failures = 0;
    int model_last = 1;
    int prev_grant = -1;

    always #5 clk = ~clk;

    mul_sched #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    endtask

    // Called at a negedge with the DUT in IDLE; ends at a negedge with the DUT back in IDLE.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int bp, input string tag);
        int exp_id;
        int lat;
        int exp_prod;
        logic [2*W-1:0] held_data;
        logic held_id;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        if (v0 && v1) exp_id = (model_last == 1) ? 0 : 1;
        else          exp_id = v0 ? 0 : 1;
        exp_prod = (exp_id == 0) ? int'(a0) * int'(b0) : int'(a1) * int'(b1);
        #1;
        chk({tag, "_ready0"}, 32'(req0_ready), 32'(exp_id == 0));
        chk({tag, "_ready1"}, 32'(req1_ready), 32'(exp_id == 1));
        @(posedge clk);
        model_last = exp_id;
        if (prev_grant >= 0 && v0 && v1)
            chk({tag, "_alternate"}, 32'(exp_id != prev_grant), 1);
        prev_grant = exp_id;
        #1;
        if (exp_id == 0) req0_valid = 1'b0;
        else             req1_valid = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 3 * W + 4; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
            if (req0_ready || req1_ready || !busy) begin
                chk({tag, "_run_ready0"}, 32'(req0_ready), 0);
                chk({tag, "_run_ready1"}, 32'(req1_ready), 0);
                chk({tag, "_run_busy"}, 32'(busy), 1);
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
        if (lat == 0) return;
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_prod));
        chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        held_data = rsp_data;
        held_id = rsp_id;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_id !== held_id
                || req0_ready || req1_ready) begin
                chk({tag, "_bp_valid"}, 32'(rsp_valid), 1);
                chk({tag, "_bp_data"}, 32'(rsp_data), 32'(held_data));
                chk({tag, "_bp_id"}, 32'(rsp_id), 32'(held_id));
                chk({tag, "_bp_ready"}, 32'(req0_ready | req1_ready), 0);
            end
        end
        if (bp >= 10) begin
            chk({tag, "_bp_hold_data"}, 32'(rsp_data), 32'(exp_prod));
            chk({tag, "_bp_hold_valid"}, 32'(rsp_valid), 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_back_idle"}, 32'(busy), 0);
        chk({tag, "_rsp_cleared"}, 32'(rsp_valid), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_last = 1;
        prev_grant = -1;
        #2;
        check_idle_outputs("reset");
        chk("reset_ready0", 32'(req0_ready), 0);
        chk("reset_ready1", 32'(req1_ready), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra0, rb0, ra1, rb1;
        bit rv0, rv1;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;

        // Reset with both requesters asserting valid: readies stay low
        do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;

        run_op(1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 0, "single");

        // Contention after reset: requester 0 first, then requester 1 with the max operands
        do_reset();
        run_op(1'b1, 1'b1, 4'd7, 4'd2, 4'd15, 4'd15, 0, "cont_first");
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15, 0, "cont_max");

        // Alternation with both requesters continuously valid
        do_reset();
        for (int n = 0; n < 4; n++)
            run_op(1'b1, 1'b1, 4'(n + 1), 4'd9, 4'(n + 7), 4'd11, 0, "alt");

        run_op(1'b1, 1'b0, 4'd6, 4'd13, 4'd0, 4'd0, 10, "backpressure");
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd9, 0, "zero_a");
        run_op(1'b1, 1'b0, 4'd12, 4'd0, 4'd0, 4'd0, 2, "zero_b");

        // Reset during RUN cycle 2 discards the operation
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9; req1_valid = 1'b0;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_run_busy_before", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("mid_run");
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        prev_grant = -1;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (rsp_valid || busy) begin
                chk("stale_rsp_valid", 32'(rsp_valid), 0);
                chk("stale_busy", 32'(busy), 0);
            end
        end
        run_op(1'b1, 1'b1, 4'd11, 4'd13, 4'd2, 4'd3, 0, "after_reset");

        // Reset while a response is waiting in DONE
        req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
        @(posedge clk);
        #1 req1_valid = 1'b0;
        for (int k = 0; k < W + 1; k++) @(negedge clk);
        chk("mid_done_valid", 32'(rsp_valid), 1);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("mid_done");
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        prev_grant = -1;

        // Random traffic
        for (int n = 0; n < 16; n++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            ra0 = W'($urandom); rb0 = W'($urandom);
            ra1 = W'($urandom); rb1 = W'($urandom);
            run_op(rv0, rv1, ra0, rb0, ra1, rb1, int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
